if_fetch_stage: RTL and testbench

Instruction-fetch stage feeding the IF/ID pipeline register. It owns the PC and issues requests to instruction memory over a req/ready handshake. It consumes branch_taken/branch_addr from the EX-stage condition checker, and honours the hazard unit's freeze.
- A one-entry skid buffer absorbs a fetch that completes while the pipeline is frozen.
- Redirects that land during an outstanding fetch are handled by a discard state.

---
 rtl/if_fetch_stage_if.sv | 24 ++
 rtl/if_fetch_stage.sv | 123 ++++++++++++
 tb/tb_if_fetch_stage.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction memory request/response bundle
interface if_fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int INSN_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ready;
    logic [INSN_W-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage with PC, skid buffer and redirect discard
module if_fetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INSN_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    if_fetch_stage_if.master  imem,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [INSN_W-1:0] if_id_insn,
    output logic              if_id_valid
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_HOLD = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] drop_addr, drop_addr_n;
    logic [ADDR_W-1:0] skid_pc, skid_pc_n;
    logic [INSN_W-1:0] skid_insn, skid_insn_n;
    logic [ADDR_W-1:0] if_id_pc_n;
    logic [INSN_W-1:0] if_id_insn_n;
    logic              if_id_valid_n;
    logic [ADDR_W-1:0] pc_inc;
    logic              fire;

    // HOLD means the skid is occupied, so requesting is suppressed there.
    assign imem.imem_req  = ~rst & (state != S_HOLD);
    assign imem.imem_addr = (state == S_DROP) ? drop_addr : pc;
    assign fire           = imem.imem_req & imem.imem_ready;
    assign pc_inc         = pc + ADDR_W'(PC_STEP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop_addr   <= '0;
            skid_pc     <= '0;
            skid_insn   <= '0;
            if_id_pc    <= '0;
            if_id_insn  <= '0;
            if_id_valid <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop_addr   <= drop_addr_n;
            skid_pc     <= skid_pc_n;
            skid_insn   <= skid_insn_n;
            if_id_pc    <= if_id_pc_n;
            if_id_insn  <= if_id_insn_n;
            if_id_valid <= if_id_valid_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        drop_addr_n   = drop_addr;
        skid_pc_n     = skid_pc;
        skid_insn_n   = skid_insn;
        if_id_pc_n    = if_id_pc;
        if_id_insn_n  = if_id_insn;
        if_id_valid_n = if_id_valid;

        if (branch_taken) begin
            // Redirect outranks freeze; flush IF/ID and drop whatever is in flight.
            if_id_valid_n = 1'b0;
            if_id_insn_n  = '0;
            pc_n          = branch_addr;
            case (state)
                S_REQ: begin
                    if (!fire) begin
                        drop_addr_n = pc;
                        state_n     = S_DROP;
                    end
                end
                S_HOLD:  state_n = S_REQ;
                S_DROP:  if (fire) state_n = S_REQ;
                default: state_n = S_REQ;
            endcase
        end else begin
            case (state)
                S_REQ: begin
                    if (fire) begin
                        pc_n = pc_inc;
                        if (freeze) begin
                            skid_pc_n   = pc_inc;
                            skid_insn_n = imem.imem_rdata;
                            state_n     = S_HOLD;
                        end else begin
                            if_id_pc_n    = pc_inc;
                            if_id_insn_n  = imem.imem_rdata;
                            if_id_valid_n = 1'b1;
                        end
                    end else if (!freeze) begin
                        if_id_valid_n = 1'b0;
                        if_id_insn_n  = '0;
                    end
                end
                S_HOLD: begin
                    if (!freeze) begin
                        if_id_pc_n    = skid_pc;
                        if_id_insn_n  = skid_insn;
                        if_id_valid_n = 1'b1;
                        state_n       = S_REQ;
                    end
                end
                S_DROP:  if (fire) state_n = S_REQ;
                default: state_n = S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    localparam logic [31:0] RDATA_KEY = 32'hA5A5_A5A5;
    localparam logic [31:0] RESET_PC  = 32'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_insn;
    logic        if_id_valid;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_stage_if #(.ADDR_W(32), .INSN_W(32)) imem ();

    assign imem.imem_rdata = imem.imem_addr ^ RDATA_KEY;

    if_fetch_stage #(
        .ADDR_W  (32),
        .INSN_W  (32),
        .RESET_PC(RESET_PC),
        .PC_STEP (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem        (imem),
        .if_id_pc    (if_id_pc),
        .if_id_insn  (if_id_insn),
        .if_id_valid (if_id_valid)
    );

    always #5 clk = ~clk;

    // Reference: pending fetched-but-frozen words live in a queue; a redirect
    // with a fetch still in flight marks that one address as junk to be eaten.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
    } entry_t;

    entry_t      skid_q[$];
    bit          m_junk;
    logic [31:0] m_junk_addr;
    logic [31:0] m_pc;
    logic [31:0] m_ifid_pc;
    logic [31:0] m_ifid_insn;
    bit          m_ifid_valid;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        skid_q.delete();
        m_junk       = 1'b0;
        m_junk_addr  = '0;
        m_pc         = RESET_PC;
        m_ifid_pc    = '0;
        m_ifid_insn  = '0;
        m_ifid_valid = 1'b0;
    endtask

    // Called at a negedge: drive, check, advance the model, wait for next negedge.
    task automatic step(input bit f, input bit b, input logic [31:0] ba, input bit r);
        bit          exp_req;
        logic [31:0] exp_addr;
        bit          done;
        freeze          = f;
        branch_taken    = b;
        branch_addr     = ba;
        imem.imem_ready = r;
        #1;
        exp_req  = (skid_q.size() == 0);
        exp_addr = m_junk ? m_junk_addr : m_pc;
        check("imem_req", 64'(imem.imem_req), 64'(exp_req));
        if (exp_req) check("imem_addr", 64'(imem.imem_addr), 64'(exp_addr));
        check("if_id_valid", 64'(if_id_valid), 64'(m_ifid_valid));
        check("if_id_insn", 64'(if_id_insn), 64'(m_ifid_insn));
        if (m_ifid_valid) check("if_id_pc", 64'(if_id_pc), 64'(m_ifid_pc));

        done = exp_req && r;
        if (b) begin
            m_ifid_valid = 1'b0;
            m_ifid_insn  = '0;
            skid_q.delete();
            if (exp_req && !done && !m_junk) m_junk_addr = m_pc;
            m_junk = exp_req && !done;
            m_pc   = ba;
        end else if (m_junk) begin
            if (done) m_junk = 1'b0;
        end else if (skid_q.size() != 0) begin
            if (!f) begin
                m_ifid_pc    = skid_q[0].pc;
                m_ifid_insn  = skid_q[0].insn;
                m_ifid_valid = 1'b1;
                skid_q.delete();
            end
        end else if (done) begin
            if (f) begin
                skid_q.push_back('{pc: m_pc + 32'd4, insn: m_pc ^ RDATA_KEY});
            end else begin
                m_ifid_pc    = m_pc + 32'd4;
                m_ifid_insn  = m_pc ^ RDATA_KEY;
                m_ifid_valid = 1'b1;
            end
            m_pc = m_pc + 32'd4;
        end else if (!f) begin
            m_ifid_valid = 1'b0;
            m_ifid_insn  = '0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check("rst_imem_req", 64'(imem.imem_req), 64'd0);
        check("rst_if_id_valid", 64'(if_id_valid), 64'd0);
        check("rst_if_id_pc", 64'(if_id_pc), 64'd0);
        check("rst_if_id_insn", 64'(if_id_insn), 64'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [31:0] ba;

    initial begin
        imem.imem_ready = 1'b0;
        model_reset();
        do_reset();

        // Streaming with ready high, then two wait states at 8.
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        // Fetch at 12, then a completion in the first frozen cycle at 16.
        step(0, 0, '0, 1);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        step(1, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        check("t3_pc_after_hold", 64'(if_id_pc), 64'd24);

        // Walk up to 0x40, then redirect while it is pending.
        for (int i = 0; i < 64 && m_pc != 32'h40; i++) step(0, 0, '0, 1);
        check("t4_reached_40", 64'(m_pc), 64'h40);
        step(0, 1, 32'h100, 0);
        step(0, 0, '0, 0);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Redirect together with freeze while holding the skid.
        step(1, 0, '0, 1);
        step(1, 1, 32'h200, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Reset in the middle of a DROP.
        step(0, 1, 32'h300, 0);
        #2;
        do_reset();
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);

        // Randomized traffic including wrap-around and unaligned targets.
        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       ba = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
                1:       ba = $urandom;
                default: ba = $urandom & 32'hFFFF_FFFC;
            endcase
            if ($urandom_range(0, 799) == 0) begin
                #2;
                do_reset();
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, ba,
                     $urandom_range(0, 4) < 3);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
